// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: score, ball count and pause timing.
// Drives gra_still and exports state/score for the text overlay.
module pong_game_ctrl #(
  parameter int BALLS       = 3,
  parameter int TIMER_TICKS = 120,
  parameter int TICK_Y      = 481,
  parameter int TICK_X      = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [1:0] game_state,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] balls_left,
  output logic       timer_run
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam logic [1:0] BALLS_V = 2'(BALLS);
  localparam logic [6:0] LOAD_V  = 7'(TIMER_TICKS - 1);

  state_t     state;
  state_t     state_n;
  logic [6:0] timer;
  logic [6:0] timer_n;
  logic [3:0] d1_n;
  logic [3:0] d0_n;
  logic [1:0] balls_n;
  logic       hit_q;
  logic       miss_q;
  logic       tick;
  logic       hit_p;
  logic       miss_p;
  logic       btn_on;
  logic       timer_up;
  logic       load;

  assign tick     = (pix_y == 10'(TICK_Y)) &&
                    (pix_x == 10'(TICK_X));
  assign hit_p    = hit & ~hit_q;
  assign miss_p   = miss & ~miss_q;
  assign btn_on   = |btn;
  assign timer_up = (timer == 7'd0);

  assign game_state = state;

  always_comb begin
    state_n = state;
    d1_n    = score_d1;
    d0_n    = score_d0;
    balls_n = balls_left;
    load    = 1'b0;
    unique case (state)
      NEWGAME: begin
        d1_n    = 4'd0;
        d0_n    = 4'd0;
        balls_n = BALLS_V;
        if (btn_on) begin
          state_n = PLAY;
          balls_n = BALLS_V - 2'd1;
        end
      end
      PLAY: begin
        if (miss_p) begin
          load = 1'b1;
          if (balls_left == 2'd0) begin
            state_n = OVER;
          end else begin
            state_n = NEWBALL;
            balls_n = balls_left - 2'd1;
          end
        end else if (hit_p) begin
          // BCD increment, 99 wraps to 00
          if (score_d0 == 4'd9) begin
            d0_n = 4'd0;
            d1_n = (score_d1 == 4'd9) ? 4'd0
                                      : score_d1 + 4'd1;
          end else begin
            d0_n = score_d0 + 4'd1;
          end
        end
      end
      NEWBALL: begin
        if (timer_up && btn_on) state_n = PLAY;
      end
      OVER: begin
        if (timer_up) begin
          state_n = NEWGAME;
          d1_n    = 4'd0;
          d0_n    = 4'd0;
          balls_n = BALLS_V;
        end
      end
      default: state_n = NEWGAME;
    endcase
  end

  // A load on the same edge as a tick takes priority
  always_comb begin
    timer_n = timer;
    if (load)
      timer_n = LOAD_V;
    else if (tick && !timer_up)
      timer_n = timer - 7'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= NEWGAME;
      score_d1   <= 4'd0;
      score_d0   <= 4'd0;
      balls_left <= BALLS_V;
      timer      <= 7'd0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      gra_still  <= 1'b1;
      timer_run  <= 1'b0;
    end else begin
      state      <= state_n;
      score_d1   <= d1_n;
      score_d0   <= d0_n;
      balls_left <= balls_n;
      timer      <= timer_n;
      hit_q      <= hit;
      miss_q     <= miss;
      gra_still  <= (state_n != PLAY);
      timer_run  <= (timer_n != 7'd0);
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl.
// Each task drives one scenario and checks its own results.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [1:0] btn;
  logic       hit;
  logic       miss;
  logic       gra_still;
  logic [1:0] game_state;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [1:0] balls_left;
  logic       timer_run;

  int asserts = 0;
  int fails   = 0;

  pong_game_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .btn        (btn),
    .hit        (hit),
    .miss       (miss),
    .gra_still  (gra_still),
    .game_state (game_state),
    .score_d1   (score_d1),
    .score_d0   (score_d0),
    .balls_left (balls_left),
    .timer_run  (timer_run)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    pix_y = 10'd481;
    pix_x = 10'd0;
    step();
    pix_y = 10'd0;
  endtask

  task automatic do_hit();
    hit = 1'b1;
    step();
    hit = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pix_x = 10'd0;
    pix_y = 10'd0;
    btn   = 2'b00;
    hit   = 1'b0;
    miss  = 1'b0;
    repeat (3) step();
    asserts++;
    if (game_state !== 2'b00) begin
      fails++;
      $display("FAIL rst_state got %0d exp 0", game_state);
    end
    asserts++;
    if (gra_still !== 1'b1 || timer_run !== 1'b0) begin
      fails++;
      $display("FAIL rst_flags still=%b run=%b exp 1 0",
               gra_still, timer_run);
    end
    reset = 1'b1;
    repeat (2) do_tick();
    repeat (3) step();
    asserts++;
    if (game_state !== 2'b00 || gra_still !== 1'b1) begin
      fails++;
      $display("FAIL idle_state got %0d/%b exp 0/1",
               game_state, gra_still);
    end
    asserts++;
    if ({score_d1, score_d0} !== 8'h00 ||
        balls_left !== 2'd3) begin
      fails++;
      $display("FAIL idle_score got %h/%0d exp 00/3",
               {score_d1, score_d0}, balls_left);
    end
  endtask

  task automatic test_start();
    btn = 2'b01;
    step();
    btn = 2'b00;
    asserts++;
    if (game_state !== 2'b01 || gra_still !== 1'b0 ||
        balls_left !== 2'd2) begin
      fails++;
      $display("FAIL start got st=%0d still=%b bl=%0d exp 1 0 2",
               game_state, gra_still, balls_left);
    end
  endtask

  task automatic test_hits();
    for (int i = 1; i <= 3; i++) begin
      hit = 1'b1;
      repeat (800) step();
      hit = 1'b0;
      step();
      asserts++;
      if ({score_d1, score_d0} !== 8'(i)) begin
        fails++;
        $display("FAIL hit_count got %h exp %0d",
                 {score_d1, score_d0}, i);
      end
    end
  endtask

  task automatic test_bcd();
    repeat (6) do_hit();
    asserts++;
    if ({score_d1, score_d0} !== 8'h09) begin
      fails++;
      $display("FAIL bcd_09 got %h exp 09", {score_d1, score_d0});
    end
    do_hit();
    asserts++;
    if ({score_d1, score_d0} !== 8'h10) begin
      fails++;
      $display("FAIL bcd_10 got %h exp 10", {score_d1, score_d0});
    end
    repeat (89) do_hit();
    asserts++;
    if ({score_d1, score_d0} !== 8'h99) begin
      fails++;
      $display("FAIL bcd_99 got %h exp 99", {score_d1, score_d0});
    end
    do_hit();
    asserts++;
    if ({score_d1, score_d0} !== 8'h00) begin
      fails++;
      $display("FAIL bcd_wrap got %h exp 00", {score_d1, score_d0});
    end
  endtask

  task automatic test_newball();
    miss = 1'b1;
    step();
    miss = 1'b0;
    asserts++;
    if (game_state !== 2'b10 || gra_still !== 1'b1 ||
        balls_left !== 2'd1 || timer_run !== 1'b1) begin
      fails++;
      $display("FAIL nb_enter st=%0d still=%b bl=%0d run=%b exp 2 1 1 1",
               game_state, gra_still, balls_left, timer_run);
    end
    btn = 2'b10;
    do_hit();
    repeat (118) do_tick();
    asserts++;
    if (game_state !== 2'b10 || timer_run !== 1'b1 ||
        {score_d1, score_d0} !== 8'h00) begin
      fails++;
      $display("FAIL nb_hold st=%0d run=%b sc=%h exp 2 1 00",
               game_state, timer_run, {score_d1, score_d0});
    end
    do_tick();
    asserts++;
    if (game_state !== 2'b10 || timer_run !== 1'b0) begin
      fails++;
      $display("FAIL nb_zero st=%0d run=%b exp 2 0",
               game_state, timer_run);
    end
    step();
    asserts++;
    if (game_state !== 2'b01 || gra_still !== 1'b0) begin
      fails++;
      $display("FAIL nb_play st=%0d still=%b exp 1 0",
               game_state, gra_still);
    end
    btn = 2'b00;
    miss = 1'b1;
    step();
    miss = 1'b0;
    btn = 2'b01;
    repeat (119) do_tick();
    step();
    btn = 2'b00;
    asserts++;
    if (game_state !== 2'b01 || balls_left !== 2'd0) begin
      fails++;
      $display("FAIL nb_last st=%0d bl=%0d exp 1 0",
               game_state, balls_left);
    end
  endtask

  task automatic test_over();
    do_hit();
    miss = 1'b1;
    pix_y = 10'd481;
    step();
    pix_y = 10'd0;
    miss = 1'b0;
    asserts++;
    if (game_state !== 2'b11 || gra_still !== 1'b1 ||
        timer_run !== 1'b1) begin
      fails++;
      $display("FAIL ov_enter st=%0d still=%b run=%b exp 3 1 1",
               game_state, gra_still, timer_run);
    end
    btn = 2'b11;
    repeat (118) do_tick();
    asserts++;
    if (game_state !== 2'b11 || timer_run !== 1'b1 ||
        {score_d1, score_d0} !== 8'h01) begin
      fails++;
      $display("FAIL ov_hold st=%0d run=%b sc=%h exp 3 1 01",
               game_state, timer_run, {score_d1, score_d0});
    end
    do_tick();
    step();
    btn = 2'b00;
    asserts++;
    if (game_state !== 2'b00 || {score_d1, score_d0} !== 8'h00 ||
        balls_left !== 2'd3) begin
      fails++;
      $display("FAIL ov_exit st=%0d sc=%h bl=%0d exp 0 00 3",
               game_state, {score_d1, score_d0}, balls_left);
    end
  endtask

  task automatic test_simul();
    btn = 2'b10;
    step();
    btn = 2'b00;
    do_hit();
    hit  = 1'b1;
    miss = 1'b1;
    step();
    hit  = 1'b0;
    miss = 1'b0;
    asserts++;
    if (game_state !== 2'b10 || {score_d1, score_d0} !== 8'h01 ||
        balls_left !== 2'd1) begin
      fails++;
      $display("FAIL simul st=%0d sc=%h bl=%0d exp 2 01 1",
               game_state, {score_d1, score_d0}, balls_left);
    end
  endtask

  task automatic test_reset_mid();
    repeat (69) do_tick();
    #2;
    reset = 1'b0;
    #1;
    asserts++;
    if (game_state !== 2'b00 || gra_still !== 1'b1 ||
        timer_run !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst st=%0d still=%b run=%b exp 0 1 0",
               game_state, gra_still, timer_run);
    end
    asserts++;
    if ({score_d1, score_d0} !== 8'h00 || balls_left !== 2'd3) begin
      fails++;
      $display("FAIL mid_rst_sc sc=%h bl=%0d exp 00 3",
               {score_d1, score_d0}, balls_left);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_start();
    test_hits();
    test_bcd();
    test_newball();
    test_over();
    test_simul();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Top-level game sequencer for the pong datapath; consumes the graphics stage's hit/miss levels and drives its gra_still input.
- Keeps a 2-digit BCD score and a balls-remaining count, and times the pause between balls and after game over.
- Decodes the frame tick from the VGA pixel counters.
- Exports state/score for the text overlay stage.

Parameters:
BALLS, 3, balls per game (2-bit range, 1..3)
TIMER_TICKS, 120, pause length in frame ticks (2 s at 60 Hz); must fit 7 bits
TICK_Y, 481, pix_y value at which the frame tick fires
TICK_X, 0, pix_x value at which the frame tick fires

Ports:
clk  in  1  system clock (pixel-rate domain)
reset  in  1  asynchronous, active-low reset
pix_x  in  10  current pixel column from VGA sync
pix_y  in  10  current pixel row from VGA sync
btn  in  2  player buttons, level, already debounced; "pressed" = any bit 1
hit  in  1  level from graphics stage: ball hit a paddle
miss  in  1  level from graphics stage: ball passed a paddle
gra_still  out  1  1 = freeze ball at centre (to graphics stage)
game_state  out  2  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER
score_d1  out  4  BCD tens
score_d0  out  4  BCD units
balls_left  out  2  balls remaining after the current one
timer_run  out  1  1 while the pause timer is nonzero

Behaviour:
- Reset (reset=0, async):
  - state=NEWGAME, score_d1=0, score_d0=0, balls_left=BALLS.
  - timer=0, hit_q=0, miss_q=0.
  - Outputs: gra_still=1, timer_run=0.
- Frame tick: tick = (pix_y==TICK_Y && pix_x==TICK_X); combinational, one clk wide per frame.
- Edge detect:
  - hit_q/miss_q register the inputs every clk.
  - hit_p = hit & ~hit_q; miss_p = miss & ~miss_q.
  - A level held for many cycles counts once.
- Timer:
  - 7-bit down counter.
  - Loaded with TIMER_TICKS-1 on the clk edge of any transition flagged "start timer" below.
  - Otherwise decrements by 1 on tick while nonzero; holds at 0.
  - timer_up = (timer==0); timer_run = ~timer_up.
- All outputs are registered (Moore). gra_still = 1 in every state except PLAY.
- FSM transitions (all take effect on the next clk edge):
  - NEWGAME:
    - Score is held at 00 and balls_left at BALLS.
    - btn!=0 -> PLAY; balls_left <= BALLS-1.
  - PLAY:
    - hit_p & ~miss_p -> BCD increment score; stay in PLAY.
    - miss_p with balls_left==0 -> OVER; start timer.
    - miss_p with balls_left!=0 -> NEWBALL; balls_left <= balls_left-1; start timer.
    - Simultaneous hit_p and miss_p: the miss wins and the score is not incremented.
  - NEWBALL:
    - Requires timer_up & btn!=0 to go to PLAY; a button held through the pause starts play the cycle the timer reaches 0.
    - hit/miss edges are ignored.
  - OVER:
    - timer_up -> NEWGAME; score clears to 00 and balls_left <= BALLS on that edge.
    - btn is ignored.
- BCD increment:
  - d0==9 -> d0=0 and d1++; d1==9 && d0==9 -> 00 (wrap, no flag).
  - Digits are never outside 0..9.
- Score is held in NEWBALL and OVER so the overlay can display it.
- Reset mid-operation: immediate return to the reset values regardless of state or timer.
- tick coincident with a timer load: the load wins (timer = TIMER_TICKS-1).

Test Plan:
- Reset low 3 clk, release; btn=00 for 2 frames -> state 00, gra_still=1, score 00, balls_left=3. Then btn=01 -> state 01 one clk later, gra_still=0, balls_left=2.
- In PLAY, 3 hit pulses each held 800 clk -> score_d1=0, score_d0=3; each pulse counts exactly once.
- Preload score 09 then 1 hit -> 10; preload 99 then 1 hit -> 00.
- In PLAY with balls_left=2, assert miss -> state 10, gra_still=1, balls_left=1, timer_run=1. With btn held: state stays 10 for 119 ticks, then goes to 01 on the clk after timer reaches 0.
- With balls_left=0, miss -> state 11. After 119 ticks -> state 00, score 00, balls_left=3. Pressing btn during OVER has no effect.
- hit and miss rise on the same clk in PLAY -> no score change, state 10. Separately, assert reset mid-NEWBALL with timer at 50 -> all outputs return to reset values asynchronously.
